// File: rtl/lia_window_sequencer.sv
// Integration-window sequencer for the lock-in amplifier: drives accumulator clear/enable/dump,
// counts windows, and holds each dumped I/Q result for a valid/ready consumer with overflow flag.
module lia_window_sequencer #(
    parameter int CNT_W  = 32,
    parameter int SET_W  = 16,
    parameter int NWIN_W = 16,
    parameter int DW     = 14
) (
    input  logic                 dac_clk_i,
    input  logic                 dac_rstn_i,
    input  logic [CNT_W-1:0]     cfg_win_len_i,
    input  logic [SET_W-1:0]     cfg_settle_i,
    input  logic [NWIN_W-1:0]    cfg_nwin_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic signed [DW-1:0] lia_i_i,
    input  logic signed [DW-1:0] lia_q_i,
    output logic                 acc_clr_o,
    output logic                 acc_en_o,
    output logic                 dump_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [NWIN_W-1:0]    win_cnt_o,
    output logic signed [DW-1:0] res_i_o,
    output logic signed [DW-1:0] res_q_o,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic                 ovf_o
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_INTEGRATE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [SET_W-1:0]  SET_ZERO  = {SET_W{1'b0}};
    localparam logic [SET_W-1:0]  SET_ONE   = {{(SET_W-1){1'b0}}, 1'b1};
    localparam logic [NWIN_W-1:0] NWIN_ZERO = {NWIN_W{1'b0}};
    localparam logic [NWIN_W-1:0] NWIN_ONE  = {{(NWIN_W-1){1'b0}}, 1'b1};
    localparam logic [NWIN_W-1:0] NWIN_ALL1 = {NWIN_W{1'b1}};
    localparam logic [DW-1:0]     DW_ZERO   = {DW{1'b0}};

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      len_m1_q, len_m1_d;
    logic [SET_W-1:0]      set_q, set_d;
    logic [NWIN_W-1:0]     nwin_q, nwin_d;
    logic                  cont_q, cont_d;
    logic [NWIN_W-1:0]     win_cnt_q, win_cnt_d;
    logic                  acc_clr_q, acc_clr_d;
    logic                  acc_en_q, acc_en_d;
    logic                  dump_q, dump_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cap_q;
    logic signed [DW-1:0]  res_i_q, res_i_d;
    logic signed [DW-1:0]  res_q_q, res_q_d;
    logic                  res_valid_q, res_valid_d;
    logic                  ovf_q, ovf_d;
    logic                  start_acc_s;
    logic                  last_win_s;

    // State, counters, registered outputs and result holding registers
    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            len_m1_q    <= CNT_ZERO;
            set_q       <= SET_ZERO;
            nwin_q      <= NWIN_ZERO;
            cont_q      <= 1'b0;
            win_cnt_q   <= NWIN_ZERO;
            acc_clr_q   <= 1'b1;
            acc_en_q    <= 1'b0;
            dump_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cap_q       <= 1'b0;
            res_i_q     <= DW_ZERO;
            res_q_q     <= DW_ZERO;
            res_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_m1_q    <= len_m1_d;
            set_q       <= set_d;
            nwin_q      <= nwin_d;
            cont_q      <= cont_d;
            win_cnt_q   <= win_cnt_d;
            acc_clr_q   <= acc_clr_d;
            acc_en_q    <= acc_en_d;
            dump_q      <= dump_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cap_q       <= dump_q;
            res_i_q     <= res_i_d;
            res_q_q     <= res_q_d;
            res_valid_q <= res_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    // dump_q marks the last count of the current window, so it doubles as the window-end flag
    assign last_win_s = !cont_q && (win_cnt_q == (nwin_q - NWIN_ONE));

    // Next-state and counter logic; stop_i overrides everything
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_m1_d    = len_m1_q;
        set_d       = set_q;
        nwin_d      = nwin_q;
        cont_d      = cont_q;
        win_cnt_d   = win_cnt_q;
        start_acc_s = 1'b0;
        if (stop_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        start_acc_s = 1'b1;
                        len_m1_d    = (cfg_win_len_i == CNT_ZERO) ? CNT_ZERO : (cfg_win_len_i - CNT_ONE);
                        set_d       = cfg_settle_i - SET_ONE;
                        nwin_d      = cfg_nwin_i;
                        cont_d      = (cfg_nwin_i == NWIN_ZERO);
                        cnt_d       = CNT_ZERO;
                        win_cnt_d   = NWIN_ZERO;
                        state_d     = (cfg_settle_i != SET_ZERO) ? ST_SETTLE : ST_INTEGRATE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (set_q == SET_ZERO) begin
                        state_d = ST_INTEGRATE;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        set_d = set_q - SET_ONE;
                    end
                end
                ST_INTEGRATE: begin
                    if (dump_q) begin
                        win_cnt_d = (win_cnt_q == NWIN_ALL1) ? win_cnt_q : (win_cnt_q + NWIN_ONE);
                        cnt_d     = CNT_ZERO;
                        if (last_win_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_INTEGRATE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the next state so every strobe leaves a flop
    always_comb begin
        acc_en_d  = (state_d == ST_INTEGRATE);
        acc_clr_d = (state_d != ST_INTEGRATE);
        busy_d    = (state_d != ST_IDLE);
        dump_d    = (state_d == ST_INTEGRATE) && (cnt_d == len_m1_d);
        done_d    = dump_q && last_win_s && !stop_i && (state_q == ST_INTEGRATE);
    end

    // Result capture one cycle after dump, valid/ready hold and sticky overflow
    always_comb begin
        ovf_d = (ovf_q && !start_acc_s) || (cap_q && res_valid_q && !res_ready_i);
        if (cap_q) begin
            res_i_d     = lia_i_i;
            res_q_d     = lia_q_i;
            res_valid_d = 1'b1;
        end else if (res_valid_q && res_ready_i) begin
            res_i_d     = res_i_q;
            res_q_d     = res_q_q;
            res_valid_d = 1'b0;
        end else begin
            res_i_d     = res_i_q;
            res_q_d     = res_q_q;
            res_valid_d = res_valid_q;
        end
    end

    assign acc_clr_o   = acc_clr_q;
    assign acc_en_o    = acc_en_q;
    assign dump_o      = dump_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign win_cnt_o   = win_cnt_q;
    assign res_i_o     = res_i_q;
    assign res_q_o     = res_q_q;
    assign res_valid_o = res_valid_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_lia_window_sequencer.sv
// Bench for lia_window_sequencer: cycle-exact strobe checks per run plus a result scoreboard.
module tb_lia_window_sequencer;

    localparam int CNT_W  = 32;
    localparam int SET_W  = 16;
    localparam int NWIN_W = 16;
    localparam int DW     = 14;

    logic              clk = 1'b0;
    logic              rstn;
    logic [CNT_W-1:0]  cfg_win_len;
    logic [SET_W-1:0]  cfg_settle;
    logic [NWIN_W-1:0] cfg_nwin;
    logic              start, stop;
    logic [DW-1:0]     lia_i, lia_q;
    logic              acc_clr, acc_en, dump, busy, done, res_valid, res_ready, ovf;
    logic [NWIN_W-1:0] win_cnt;
    logic [DW-1:0]     res_i, res_q;

    int checks   = 0;
    int failures = 0;

    always #4 clk = ~clk;

    lia_window_sequencer #(.CNT_W(CNT_W), .SET_W(SET_W), .NWIN_W(NWIN_W), .DW(DW)) dut (
        .dac_clk_i(clk), .dac_rstn_i(rstn),
        .cfg_win_len_i(cfg_win_len), .cfg_settle_i(cfg_settle), .cfg_nwin_i(cfg_nwin),
        .start_i(start), .stop_i(stop), .lia_i_i(lia_i), .lia_q_i(lia_q),
        .acc_clr_o(acc_clr), .acc_en_o(acc_en), .dump_o(dump), .busy_o(busy), .done_o(done),
        .win_cnt_o(win_cnt), .res_i_o(res_i), .res_q_o(res_q), .res_valid_o(res_valid),
        .res_ready_i(res_ready), .ovf_o(ovf)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: values driven on dump+1 are pushed, popped when the capture should appear
    logic [2*DW-1:0] sb_q[$];
    logic [DW-1:0]   m_i, m_q;
    logic            m_valid   = 1'b0;
    bit              cap_pend  = 1'b0;
    bit              dump_prev = 1'b0;
    logic            rdy_edge;
    int              push_n    = 0;

    always @(posedge clk) begin
        rdy_edge = res_ready;
        #1;
        if (!rstn) begin
            m_valid   = 1'b0;
            cap_pend  = 1'b0;
            dump_prev = 1'b0;
            sb_q.delete();
            lia_i     = DW'($urandom);
            lia_q     = DW'($urandom);
        end else begin
            if (cap_pend) begin
                if (sb_q.size() > 0) begin
                    {m_i, m_q} = sb_q.pop_front();
                end
                m_valid = 1'b1;
            end else if (m_valid && rdy_edge) begin
                m_valid = 1'b0;
            end
            chk_eq("sb.res_valid", res_valid, m_valid);
            if (m_valid) begin
                chk_eq("sb.res_i", res_i, m_i);
                chk_eq("sb.res_q", res_q, m_q);
            end
            cap_pend = dump_prev;
            if (cap_pend) begin
                if (push_n == 0) begin
                    lia_i = 14'h0123;
                    lia_q = 14'h3F00;
                end else begin
                    lia_i = DW'($urandom);
                    lia_q = DW'($urandom);
                end
                push_n++;
                sb_q.push_back({lia_i, lia_q});
            end else begin
                lia_i = DW'($urandom);
                lia_q = DW'($urandom);
            end
            dump_prev = dump;
        end
    end

    // Runs ncyc cycles from a start at t=0, checking strobes against the expected timeline
    task automatic run_win(input string tag, input int ncyc, input int d0, input int d1,
                           input int d2, input int d3, input int done_t, input int clr_last,
                           input int busy_last, input int stop_t, input int chg_t);
        bit is_dump, in_run, integ;
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            is_dump = (t == d0) || (t == d1) || (t == d2) || (t == d3);
            in_run  = (t >= 1) && (t <= busy_last);
            integ   = in_run && (t > clr_last);
            chk_eq({tag, ".dump"}, dump, is_dump);
            chk_eq({tag, ".done"}, done, (t == done_t));
            chk_eq({tag, ".busy"}, busy, in_run);
            chk_eq({tag, ".acc_clr"}, acc_clr, !integ);
            chk_eq({tag, ".acc_en"}, acc_en, integ);
            start = (t == 0) || (t == chg_t);
            stop  = (t == stop_t);
            if (t == chg_t) begin
                cfg_win_len = 32'd50;
                cfg_nwin    = 16'd1;
                cfg_settle  = 16'd3;
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        rstn        = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        res_ready   = 1'b1;
        cfg_win_len = 32'd0;
        cfg_settle  = 16'd0;
        cfg_nwin    = 16'd0;
        lia_i       = 14'd0;
        lia_q       = 14'd0;
        repeat (2) @(negedge clk);
        chk_eq("rst.acc_clr", acc_clr, 1'b1);
        chk_eq("rst.acc_en", acc_en, 1'b0);
        chk_eq("rst.dump", dump, 1'b0);
        chk_eq("rst.busy", busy, 1'b0);
        chk_eq("rst.done", done, 1'b0);
        chk_eq("rst.valid", res_valid, 1'b0);
        chk_eq("rst.ovf", ovf, 1'b0);
        chk_eq("rst.win_cnt", win_cnt, 16'd0);
        chk_eq("rst.res_i", res_i, 14'd0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        cfg_settle = 16'd5; cfg_win_len = 32'd125; cfg_nwin = 16'd3;
        run_win("settle", 384, 130, 255, 380, -1, 381, 5, 380, -1, -1);
        chk_eq("settle.win_cnt", win_cnt, 16'd3);

        cfg_settle = 16'd0; cfg_win_len = 32'd0; cfg_nwin = 16'd4;
        run_win("len0", 8, 1, 2, 3, 4, 5, 0, 4, -1, -1);
        chk_eq("len0.win_cnt", win_cnt, 16'd4);

        cfg_settle = 16'd0; cfg_win_len = 32'd10; cfg_nwin = 16'd0;
        res_ready = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (t == 21) chk_eq("ovf.before", ovf, 1'b0);
            if (t == 22) begin
                chk_eq("ovf.set", ovf, 1'b1);
                chk_eq("ovf.valid", res_valid, 1'b1);
            end
            if (t == 24) begin
                chk_eq("ovf.valid_drop", res_valid, 1'b0);
                chk_eq("ovf.sticky", ovf, 1'b1);
            end
            if (t == 28) begin
                chk_eq("ovf.idle", busy, 1'b0);
                chk_eq("ovf.after_stop", ovf, 1'b1);
                chk_eq("ovf.win_cnt", win_cnt, 16'd2);
            end
            start     = (t == 0);
            stop      = (t == 26);
            res_ready = (t >= 23);
        end
        start = 1'b0; stop = 1'b0;

        cfg_win_len = 32'd10; cfg_nwin = 16'd2;
        run_win("stop", 24, 10, -1, -1, -1, -1, 0, 19, 19, -1);
        chk_eq("stop.win_cnt", win_cnt, 16'd1);
        chk_eq("stop.ovf_cleared", ovf, 1'b0);

        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        chk_eq("ss.busy", busy, 1'b0);
        chk_eq("ss.acc_clr", acc_clr, 1'b1);
        chk_eq("ss.win_cnt", win_cnt, 16'd1);

        cfg_win_len = 32'd20; cfg_nwin = 16'd3; cfg_settle = 16'd0;
        run_win("cfgchg", 64, 20, 40, 60, -1, 61, 0, 60, -1, 5);
        chk_eq("cfgchg.win_cnt", win_cnt, 16'd3);

        cfg_win_len = 32'd10; cfg_nwin = 16'd0; cfg_settle = 16'd2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        chk_eq("rmid.pre_win_cnt", win_cnt, 16'd2);
        chk_eq("rmid.pre_busy", busy, 1'b1);
        rstn = 1'b0;
        #1;
        chk_eq("rmid.busy", busy, 1'b0);
        chk_eq("rmid.acc_clr", acc_clr, 1'b1);
        chk_eq("rmid.acc_en", acc_en, 1'b0);
        chk_eq("rmid.win_cnt", win_cnt, 16'd0);
        chk_eq("rmid.res_i", res_i, 14'd0);
        chk_eq("rmid.res_q", res_q, 14'd0);
        chk_eq("rmid.valid", res_valid, 1'b0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        chk_eq("rmid.after_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lia_window_sequencer.md
Name: lia_window_sequencer

Overview:
- Sequences the lock-in amplifier's demodulation accumulators.
- Generates the accumulator clear, enable and dump strobes that close each integration window.
- Inserts a programmable settling blank after start, and runs N windows or runs continuously.
- Captures the scaled in-phase/quadrature results one cycle after each dump and presents them to a downstream consumer through a valid/ready handshake with overflow detection.

Parameters:
- CNT_W, 32, width of window-length counter (cycles per integration window)
- SET_W, 16, width of settle counter
- NWIN_W, 16, width of window-count configuration and status
- DW, 14, width of captured I/Q result words (signed)

Ports:
- dac_clk_i  in  1  125 MHz clock; all logic on rising edge
- dac_rstn_i  in  1  asynchronous active-low reset
- cfg_win_len_i  in  CNT_W  cycles per window; 0 treated as 1
- cfg_settle_i  in  SET_W  blank cycles before first window
- cfg_nwin_i  in  NWIN_W  windows per run; 0 = continuous
- start_i  in  1  single-cycle run request; ignored unless IDLE
- stop_i  in  1  abort; highest priority
- lia_i_i  in  DW  signed in-phase result from LIA
- lia_q_i  in  DW  signed quadrature result from LIA
- acc_clr_o  out  1  accumulator clear
- acc_en_o  out  1  accumulate enable
- dump_o  out  1  single-cycle window-close strobe to LIA
- busy_o  out  1  high in any state but IDLE
- done_o  out  1  single-cycle pulse at normal run completion
- win_cnt_o  out  NWIN_W  windows completed in current run
- res_i_o  out  DW  held in-phase result
- res_q_o  out  DW  held quadrature result
- res_valid_o  out  1  result available
- res_ready_i  in  1  consumer accepts result when valid&ready
- ovf_o  out  1  sticky: unread result overwritten

Behaviour:
- Reset (async assert, sync release) values:
  - acc_clr_o=1; acc_en_o, dump_o, busy_o, done_o, res_valid_o, ovf_o=0.
  - win_cnt_o=0; res_i_o=res_q_o=0.
  - state=IDLE.
- Configuration: cfg_* sampled only on the accepted start_i cycle; changes during a run have no effect.
- IDLE:
  - acc_clr_o=1, acc_en_o=0.
  - On start_i: clear win_cnt_o and ovf_o, load counters.
  - Next state is SETTLE if cfg_settle_i>0, else INTEGRATE.
- SETTLE:
  - acc_clr_o=1, acc_en_o=0.
  - Exactly cfg_settle cycles, then INTEGRATE.
- INTEGRATE:
  - acc_clr_o=0, acc_en_o=1.
  - Window counter runs 0..L-1 (L = max(cfg_win_len,1)).
  - On count L-1: dump_o=1 for that cycle only, and win_cnt_o increments on the following edge.
  - If continuous, or win_cnt+1 < cfg_nwin: counter wraps to 0 and integration continues with no gap. Dump period is exactly L cycles.
  - Else: go to IDLE, and done_o pulses on the cycle after the final dump.
- stop_i, any state:
  - Next state IDLE, acc_clr_o=1 next cycle.
  - No dump_o or done_o generated.
  - win_cnt_o retains its value.
  - stop_i together with start_i in IDLE: stay IDLE.
- Capture: lia_i_i/lia_q_i are registered into res_*_o on the cycle after dump_o (1-cycle LIA output latency).
- Handshake rules:
  - res_valid_o is set on capture and cleared on valid&ready with no simultaneous capture.
  - Capture together with valid&ready: new data loaded, valid stays 1, no overflow.
  - Capture with valid&!ready: data overwritten and ovf_o set, sticky until next accepted start.
  - res_*_o stable while valid&!ready.
  - Capture after a stop_i still occurs if dump_o fired on the previous cycle.
- win_cnt_o saturates at all-ones in continuous mode.
- Worst-case path: CNT_W-bit compare plus increment, single cycle at 125 MHz.

Test Plan:
- Reset mid-run (in INTEGRATE) -> all outputs return to reset values immediately; busy_o=0, acc_clr_o=1.
- settle=5, win_len=125, nwin=3, ready tied 1, start at T0:
  - acc_clr_o high T0..T5.
  - dump_o at T130, T255, T380.
  - done_o at T381; win_cnt_o=3.
  - res_valid_o pulses one cycle after each dump, carrying lia_i_i/lia_q_i values driven on dump+1 (e.g. 0x0123/0x3F00).
- win_len=0, settle=0, nwin=4 -> dump_o on 4 consecutive cycles; win_cnt_o=4; done_o pulses.
- nwin=0, win_len=10, res_ready_i=0:
  - second capture sets ovf_o=1 and res_i_o holds the second value.
  - Raise ready -> valid drops next cycle; ovf_o stays 1 until the next start.
- stop_i on the count-8 cycle of a win_len=10 window -> no dump_o, no done_o, IDLE next cycle, win_cnt_o unchanged.
- cfg_win_len_i changed from 20 to 50 mid-run -> dump period stays 20; start_i pulsed while busy is ignored.
